// File: rtl/ex_hazard_tracker_if.sv
// Bundle between the ID/EX control logic and the hazard tracker.
// The tracker takes the slave side. Whoever drives the ID fields takes the master side.
interface ex_hazard_tracker_if #(
    parameter int unsigned REGFILE_LOGSIZE = 5,
    parameter int unsigned CNT_WIDTH       = 16
);
    logic                       id_valid;
    logic [REGFILE_LOGSIZE-1:0] id_rs1;
    logic [REGFILE_LOGSIZE-1:0] id_rs2;
    logic                       id_use_rs1;
    logic                       id_use_rs2;
    logic [REGFILE_LOGSIZE-1:0] id_rd;
    logic                       id_regwrite;
    logic                       id_memread;
    logic                       flush;
    logic                       mem_busy;

    logic                       hazard_stall;
    logic                       ex_valid;
    logic [REGFILE_LOGSIZE-1:0] ex_rs1;
    logic [REGFILE_LOGSIZE-1:0] ex_rs2;
    logic [REGFILE_LOGSIZE-1:0] mem_rd;
    logic                       mem_we;
    logic [REGFILE_LOGSIZE-1:0] wb_rd;
    logic                       wb_we;
    logic [CNT_WIDTH-1:0]       stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, flush, mem_busy,
        input  hazard_stall, ex_valid, ex_rs1, ex_rs2,
               mem_rd, mem_we, wb_rd, wb_we, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_memread, flush, mem_busy,
        output hazard_stall, ex_valid, ex_rs1, ex_rs2,
               mem_rd, mem_we, wb_rd, wb_we, stall_cnt
    );
endinterface

// File: rtl/ex_hazard_tracker.sv
// Holds the EX/MEM/WB register-tag pipeline for the forwarding unit.
// Detects load-use hazards, inserts EX bubbles and counts stall cycles.
module ex_hazard_tracker #(
    parameter int unsigned REGFILE_LOGSIZE = 5,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ex_hazard_tracker_if.slave   bus
);
    localparam int unsigned RLS = REGFILE_LOGSIZE;

    typedef struct packed {
        logic           valid;
        logic [RLS-1:0] rs1;
        logic [RLS-1:0] rs2;
        logic [RLS-1:0] rd;
        logic           we;
        logic           ld;
    } ex_entry_t;

    typedef struct packed {
        logic [RLS-1:0] rd;
        logic           we;
    } dst_entry_t;

    ex_entry_t            ex_q,  ex_d;
    dst_entry_t           mem_q, mem_d;
    dst_entry_t           wb_q,  wb_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard_c;
    logic rs1_hit_c;
    logic rs2_hit_c;
    logic id_we_c;

    // Load-use detection against the instruction currently in EX; a flush kills the consumer.
    always_comb begin
        rs1_hit_c = bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd);
        rs2_hit_c = bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd);
        hazard_c  = bus.id_valid && ex_q.valid && ex_q.ld && ex_q.we &&
                    !bus.flush && (rs1_hit_c || rs2_hit_c);
        id_we_c   = bus.id_regwrite && (bus.id_rd != '0);
    end

    // Next-state: hold everything while memory is busy, otherwise advance one stage.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.mem_busy) begin
            wb_d     = mem_q;
            mem_d.rd = ex_q.rd;
            mem_d.we = ex_q.we && ex_q.valid;
            if (bus.flush || hazard_c || !bus.id_valid) begin
                ex_d = '0;
            end else begin
                ex_d.valid = 1'b1;
                ex_d.rs1   = bus.id_use_rs1 ? bus.id_rs1 : '0;
                ex_d.rs2   = bus.id_use_rs2 ? bus.id_rs2 : '0;
                ex_d.rd    = bus.id_rd;
                ex_d.we    = id_we_c;
                ex_d.ld    = bus.id_memread;
            end
            if (hazard_c && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.hazard_stall = hazard_c;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_rs1       = ex_q.rs1;
    assign bus.ex_rs2       = ex_q.rs2;
    assign bus.mem_rd       = mem_q.rd;
    assign bus.mem_we       = mem_q.we;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.wb_we        = wb_q.we;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_ex_hazard_tracker.sv
// Directed bench for ex_hazard_tracker. The counter is kept narrow so that saturation is reachable.
module tb_ex_hazard_tracker;
    localparam int unsigned RLS = 5;
    localparam int unsigned CW  = 4;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    ex_hazard_tracker_if #(.REGFILE_LOGSIZE(RLS), .CNT_WIDTH(CW)) bus ();

    ex_hazard_tracker #(.REGFILE_LOGSIZE(RLS), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_use_rs1  = u1;
        bus.id_rs2      = rs2;
        bus.id_use_rs2  = u2;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (3) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ex_valid"},  16'(bus.ex_valid), 16'd0);
        chk({tag, ".ex_rs1"},    16'(bus.ex_rs1), 16'd0);
        chk({tag, ".ex_rs2"},    16'(bus.ex_rs2), 16'd0);
        chk({tag, ".mem_rd"},    16'(bus.mem_rd), 16'd0);
        chk({tag, ".mem_we"},    16'(bus.mem_we), 16'd0);
        chk({tag, ".wb_rd"},     16'(bus.wb_rd), 16'd0);
        chk({tag, ".wb_we"},     16'(bus.wb_we), 16'd0);
        chk({tag, ".stall_cnt"}, 16'(bus.stall_cnt), 16'd0);
        chk({tag, ".hazard"},    16'(bus.hazard_stall), 16'd0);
    endtask

    // Load x7, then a consumer of x7 that stalls for one edge, then an idle edge.
    task automatic load_use();
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        idle();
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.flush    = 1'b0;
        bus.mem_busy = 1'b0;
        idle();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk_zero("reset");

        // add x5 <- x1,x2 followed by sub x8 <- x5,x6
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        chk("add.ex_valid", 16'(bus.ex_valid), 16'd1);
        chk("add.ex_rs1",   16'(bus.ex_rs1), 16'd1);
        chk("add.ex_rs2",   16'(bus.ex_rs2), 16'd2);
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        chk("sub.no_hazard", 16'(bus.hazard_stall), 16'd0);
        tick();
        chk("sub.ex_rs1", 16'(bus.ex_rs1), 16'd5);
        chk("sub.mem_rd", 16'(bus.mem_rd), 16'd5);
        chk("sub.mem_we", 16'(bus.mem_we), 16'd1);
        idle();
        tick();
        chk("add.wb_rd",  16'(bus.wb_rd), 16'd5);
        chk("add.wb_we",  16'(bus.wb_we), 16'd1);
        chk("sub.mem_rd2", 16'(bus.mem_rd), 16'd8);
        chk("idle.ex_valid", 16'(bus.ex_valid), 16'd0);
        drain();

        // load x7 then add reading x7 on rs2
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        chk("lu.hazard", 16'(bus.hazard_stall), 16'd1);
        tick();
        chk("lu.bubble",    16'(bus.ex_valid), 16'd0);
        chk("lu.mem_rd",    16'(bus.mem_rd), 16'd7);
        chk("lu.mem_we",    16'(bus.mem_we), 16'd1);
        chk("lu.stall_cnt", 16'(bus.stall_cnt), 16'd1);
        chk("lu.hazard_off", 16'(bus.hazard_stall), 16'd0);
        tick();
        chk("lu.add_ex_valid", 16'(bus.ex_valid), 16'd1);
        chk("lu.add_ex_rs2",   16'(bus.ex_rs2), 16'd7);
        chk("lu.mem_bubble",   16'(bus.mem_we), 16'd0);
        chk("lu.wb_rd",        16'(bus.wb_rd), 16'd7);
        drain();

        // same hazard with a flush: flush wins, no count
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        bus.flush = 1'b1;
        drive(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        chk("fl.hazard", 16'(bus.hazard_stall), 16'd0);
        tick();
        bus.flush = 1'b0;
        chk("fl.bubble",    16'(bus.ex_valid), 16'd0);
        chk("fl.stall_cnt", 16'(bus.stall_cnt), 16'd1);
        chk("fl.mem_rd",    16'(bus.mem_rd), 16'd7);
        drain();

        // load x0 never forwards or stalls
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
        chk("x0.hazard", 16'(bus.hazard_stall), 16'd0);
        tick();
        chk("x0.mem_we",   16'(bus.mem_we), 16'd0);
        chk("x0.ex_valid", 16'(bus.ex_valid), 16'd1);
        drain();

        // load x3, consumer names x3 on rs1 but does not use it
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd3, 1'b0, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);
        chk("nouse.hazard", 16'(bus.hazard_stall), 16'd0);
        tick();
        chk("nouse.ex_rs1", 16'(bus.ex_rs1), 16'd0);
        chk("nouse.ex_rs2", 16'(bus.ex_rs2), 16'd4);
        chk("nouse.stall_cnt", 16'(bus.stall_cnt), 16'd1);
        drain();

        // memory freeze during a load-use hazard
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        bus.mem_busy = 1'b1;
        drive(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("busy.hazard",    16'(bus.hazard_stall), 16'd1);
            chk("busy.ex_rs1",    16'(bus.ex_rs1), 16'd1);
            chk("busy.mem_rd",    16'(bus.mem_rd), 16'd0);
            chk("busy.stall_cnt", 16'(bus.stall_cnt), 16'd1);
        end
        bus.mem_busy = 1'b0;
        tick();
        chk("busy.rel_bubble", 16'(bus.ex_valid), 16'd0);
        chk("busy.rel_mem_rd", 16'(bus.mem_rd), 16'd7);
        chk("busy.rel_cnt",    16'(bus.stall_cnt), 16'd2);
        drain();

        // saturate the counter: 13 more stalls reach all-ones, one more must hold
        for (int i = 0; i < 13; i++) load_use();
        chk("sat.reach", 16'(bus.stall_cnt), 16'hF);
        load_use();
        chk("sat.hold", 16'(bus.stall_cnt), 16'hF);
        drain();

        // reset in the middle of a frozen stall
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        bus.mem_busy = 1'b1;
        bus.flush    = 1'b0;
        drive(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);
        chk("rst.pre_hazard", 16'(bus.hazard_stall), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_busy = 1'b0;
        idle();
        chk_zero("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
